aes128_iter_core: RTL and testbench



---
 rtl/aes128_iter_core.sv | 325 ++++++++++++++++++++++++++++++++
 tb/tb_aes128_iter_core.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/aes128_iter_core.sv
// aes128_iter_core: iterative AES-128 encrypt/decrypt, one round per clock,
// round keys generated on the fly (forward schedule for encrypt, a forward
// pass to k10 followed by the inverse schedule for decrypt).
// Optional build macro AES128_KEY_CACHE_EN: remembers the last decrypt key
// together with its k10 so a repeated decrypt key skips the expansion pass.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | ready=1, waiting for start
// S_KEXP  | decrypt only: forward key expansion k0 -> k10 (10 cycles)
// S_ROUND | one cipher round per cycle (rnd_q counts up for enc, down for dec)
module aes128_iter_core (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         mode,
  input  logic [127:0] key,
  input  logic [127:0] din,
  output logic         ready,
  output logic         done,
  output logic [127:0] dout
);

  typedef enum logic [1:0] {S_IDLE, S_KEXP, S_ROUND} fsm_e;

  // Byte n of each table sits at bits [2047-8n -: 8].
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[8*(255-int'(b)) +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX_TBL[8*(255-int'(b)) +: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
    return o;
  endfunction

  // Byte (c,r) is byte 4c+r, counted from the MSB end.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                           xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a [4];
    logic [7:0]   m9 [4], mb [4], md [4], me [4];
    logic [7:0]   x2, x4, x8;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        a[r]  = s[127-8*(4*c+r) -: 8];
        x2    = xt(a[r]);
        x4    = xt(x2);
        x8    = xt(x4);
        m9[r] = x8 ^ a[r];
        mb[r] = x8 ^ x2 ^ a[r];
        md[r] = x8 ^ x4 ^ a[r];
        me[r] = x8 ^ x4 ^ x2;
      end
      o[127-32*c -: 32] = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                           m9[0] ^ me[1] ^ mb[2] ^ md[3],
                           md[0] ^ m9[1] ^ me[2] ^ mb[3],
                           mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    end
    return o;
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h0};
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0]  ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Recovers k[i-1] from k[i]; rc is the Rcon that produced k[i].
  function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] p0, p1, p2, p3;
    p3 = k[31:0]  ^ k[63:32];
    p2 = k[63:32] ^ k[95:64];
    p1 = k[95:64] ^ k[127:96];
    p0 = k[127:96] ^ sub_rot_word(p3) ^ {rc, 24'h0};
    return {p0, p1, p2, p3};
  endfunction

  fsm_e         fsm_q, fsm_d;
  logic [127:0] blk_q, blk_d;
  logic [127:0] rk_q, rk_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         dec_q, dec_d;
  logic         ready_q, ready_d;
  logic         done_q, done_d;
  logic [127:0] dout_q, dout_d;
  logic         cache_hit;
`ifdef AES128_KEY_CACHE_EN
  logic         cache_vld_q, cache_vld_d;
  logic [127:0] cache_key_q, cache_key_d;
  logic [127:0] cache_k10_q, cache_k10_d;
`endif

  logic [127:0] fwd_rk, inv_rk;
  logic [127:0] enc_tmp, enc_out, dec_tmp, dec_out;

  // Round datapath and key schedule, evaluated every cycle from the current round key.
  always_comb begin
    fwd_rk  = key_fwd(rk_q, rcon(rnd_q));
    inv_rk  = key_inv(rk_q, rcon(rnd_q));
    enc_tmp = shift_rows(sub_bytes(blk_q));
    enc_out = ((rnd_q == 4'd10) ? enc_tmp : mix_columns(enc_tmp)) ^ fwd_rk;
    dec_tmp = inv_sub_bytes(inv_shift_rows(blk_q)) ^ inv_rk;
    dec_out = (rnd_q == 4'd1) ? dec_tmp : inv_mix_columns(dec_tmp);
  end

  // Next-state logic for the controller, round state, result and key cache.
  always_comb begin
    fsm_d   = fsm_q;
    blk_d   = blk_q;
    rk_d    = rk_q;
    rnd_d   = rnd_q;
    dec_d   = dec_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    dout_d  = dout_q;
`ifdef AES128_KEY_CACHE_EN
    cache_vld_d = cache_vld_q;
    cache_key_d = cache_key_q;
    cache_k10_d = cache_k10_q;
    cache_hit   = cache_vld_q && (key == cache_key_q);
`else
    cache_hit   = 1'b0;
`endif
    case (fsm_q)
      S_IDLE: begin
        if (start && ready_q) begin
          ready_d = 1'b0;
          dec_d   = mode;
          if (!mode) begin
            blk_d = din ^ key;
            rk_d  = key;
            rnd_d = 4'd1;
            fsm_d = S_ROUND;
          end else if (cache_hit) begin
`ifdef AES128_KEY_CACHE_EN
            blk_d = din ^ cache_k10_q;
            rk_d  = cache_k10_q;
`endif
            rnd_d = 4'd10;
            fsm_d = S_ROUND;
          end else begin
            blk_d = din;
            rk_d  = key;
            rnd_d = 4'd1;
            fsm_d = S_KEXP;
`ifdef AES128_KEY_CACHE_EN
            // Key is captured now but only trusted once its k10 is known.
            cache_vld_d = 1'b0;
            cache_key_d = key;
`endif
          end
        end
      end
      S_KEXP: begin
        rk_d  = fwd_rk;
        rnd_d = rnd_q + 4'd1;
        if (rnd_q == 4'd10) begin
          blk_d = blk_q ^ fwd_rk;
          rnd_d = 4'd10;
          fsm_d = S_ROUND;
`ifdef AES128_KEY_CACHE_EN
          cache_vld_d = 1'b1;
          cache_k10_d = fwd_rk;
`endif
        end
      end
      S_ROUND: begin
        if (!dec_q) begin
          blk_d = enc_out;
          rk_d  = fwd_rk;
          rnd_d = rnd_q + 4'd1;
          if (rnd_q == 4'd10) begin
            dout_d  = enc_out;
            done_d  = 1'b1;
            ready_d = 1'b1;
            fsm_d   = S_IDLE;
          end
        end else begin
          blk_d = dec_out;
          rk_d  = inv_rk;
          rnd_d = rnd_q - 4'd1;
          if (rnd_q == 4'd1) begin
            dout_d  = dec_out;
            done_d  = 1'b1;
            ready_d = 1'b1;
            fsm_d   = S_IDLE;
          end
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any operation in flight and drops the cache.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= S_IDLE;
      blk_q   <= '0;
      rk_q    <= '0;
      rnd_q   <= '0;
      dec_q   <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      dout_q  <= '0;
`ifdef AES128_KEY_CACHE_EN
      cache_vld_q <= 1'b0;
      cache_key_q <= '0;
      cache_k10_q <= '0;
`endif
    end else begin
      fsm_q   <= fsm_d;
      blk_q   <= blk_d;
      rk_q    <= rk_d;
      rnd_q   <= rnd_d;
      dec_q   <= dec_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      dout_q  <= dout_d;
`ifdef AES128_KEY_CACHE_EN
      cache_vld_q <= cache_vld_d;
      cache_key_q <= cache_key_d;
      cache_k10_q <= cache_k10_d;
`endif
    end
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign dout  = dout_q;

endmodule

// File: tb/tb_aes128_iter_core.sv
// Scoreboard bench for aes128_iter_core: stimulus pushes expected result and
// latency at the accepting edge; a negedge monitor pops on every done pulse.
module tb_aes128_iter_core;

  logic         clk = 1'b0;
  logic         rst, start, mode;
  logic [127:0] key, din;
  logic         ready, done;
  logic [127:0] dout;

  aes128_iter_core dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .key(key), .din(din), .ready(ready), .done(done), .dout(dout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] exp;
    logic         chk_data;
    int           e0;
    int           lat;
    string        tag;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   last_done = -100;

  logic         m_cache_vld = 1'b0;
  logic [127:0] m_cache_key = '0;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] CX = 128'hc47730b1d21a924ae41344842da007ab;
  logic [127:0] k3 = "password123";
  logic [127:0] p3 = "sentence2encrypt";

  task automatic check_vec(input string name, input logic [127:0] act, input logic [127:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic check_int(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic int exp_lat(input logic m, input logic [127:0] k);
    if (!m) return 10;
`ifdef AES128_KEY_CACHE_EN
    if (m_cache_vld && (k == m_cache_key)) return 10;
`endif
    return 20;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request.
  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst && done) begin
      last_done = cyc;
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done with dout %h, expected no done", dout);
      end else begin
        mon_e = sb_q.pop_front();
        if (mon_e.chk_data) check_vec({mon_e.tag, "_dout"}, dout, mon_e.exp);
        check_int({mon_e.tag, "_latency"}, cyc - mon_e.e0, mon_e.lat);
      end
    end
  end

  task automatic issue(input logic m, input logic [127:0] k, input logic [127:0] d,
                       input logic [127:0] expv, input logic chk, input string tag,
                       input logic push, output int e0);
    int   w;
    int   lat;
    exp_t e;
    w = 0;
    @(negedge clk);
    while (!ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_ready_timeout: got ready=0 expected ready=1", tag);
    end
    lat   = exp_lat(m, k);
    start = 1'b1;
    mode  = m;
    key   = k;
    din   = d;
    @(posedge clk);
    #1;
    e0 = cyc;
    if (push) begin
      e.exp = expv; e.chk_data = chk; e.e0 = e0; e.lat = lat; e.tag = tag;
      sb_q.push_back(e);
    end
    if (m && lat == 20) begin
      m_cache_vld = 1'b1;
      m_cache_key = k;
    end
    start = 1'b0;
    mode  = ~m;
    key   = {$urandom, $urandom, $urandom, $urandom};
    din   = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_done(input string tag, output logic [127:0] v);
    int w;
    w = 0;
    @(negedge clk);
    while (!done && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_done_timeout: got done=0 expected done=1", tag);
    end
    v = dout;
  endtask

  initial begin
    int           e0, e0b, w;
    logic [127:0] v;
    rst = 1'b1; start = 1'b0; mode = 1'b0; key = '0; din = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_int("reset_ready", int'(ready), 1);
    check_int("reset_done", int'(done), 0);
    check_vec("reset_dout", dout, '0);
    @(posedge clk);
    #1 rst = 1'b0;

    issue(1'b0, K1, P1, C1, 1'b1, "enc_fips", 1'b1, e0);
    issue(1'b1, K1, C1, P1, 1'b1, "dec_fips", 1'b1, e0);
    issue(1'b1, K1, C1, P1, 1'b1, "dec_fips_again", 1'b1, e0b);
    check_int("b2b_no_gap", e0b, last_done + 1);
    check_int("ready_low_busy", int'(ready), 0);

    // Busy start plus changed inputs must leave this encrypt untouched.
    issue(1'b0, K2, P2, C2, 1'b1, "enc_sp800_busy", 1'b1, e0);
    repeat (3) @(posedge clk);
    #1 start = 1'b1; mode = 1'b1; key = K1; din = C1;
    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    issue(1'b1, K2, C2, P2, 1'b1, "dec_sp800", 1'b1, e0);

    issue(1'b0, k3, p3, '0, 1'b0, "enc_ascii", 1'b1, e0);
    wait_done("enc_ascii", v);
    issue(1'b1, k3, v, p3, 1'b1, "dec_ascii_roundtrip", 1'b1, e0);
    issue(1'b1, k3, CX, '0, 1'b0, "dec_ref_ct", 1'b1, e0);
    wait_done("dec_ref_ct", v);
    issue(1'b0, k3, v, CX, 1'b1, "enc_ref_roundtrip", 1'b1, e0);

    // Reset in the fifth cycle of a decrypt: no done, cleared outputs.
    issue(1'b1, K1, C1, P1, 1'b0, "dec_aborted", 1'b0, e0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    m_cache_vld = 1'b0;
    check_int("abort_ready", int'(ready), 1);
    check_int("abort_done", int'(done), 0);
    check_vec("abort_dout", dout, '0);
    repeat (25) @(posedge clk);
    #1;
    check_vec("abort_dout_hold", dout, '0);
    issue(1'b1, K1, C1, P1, 1'b1, "dec_after_reset", 1'b1, e0);

    w = 0;
    while (sb_q.size() != 0 && w < 100) begin
      @(posedge clk);
      w++;
    end
    @(negedge clk);
    check_int("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
